// File: rtl/esi_manifest_pkg.sv
// Shared constants and helpers for the ESI manifest MMIO reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package esi_manifest_pkg;

  // Header word layout.
  localparam int unsigned SIZE_LSB    = 0;
  localparam int unsigned VERSION_LSB = 32;

  // Bytes per 64-bit MMIO word.
  localparam int unsigned WORD_BYTES  = 8;

  // Number of data words needed to carry 'size' manifest bytes.
  function automatic int unsigned num_words(input int unsigned size);
    return (size + WORD_BYTES - 1) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/esi_manifest_word_sel.sv
// Maps a word index to the header word or a zero-padded manifest data word.
// Latency: purely combinational.
// Backpressure: none; the caller owns all handshaking.
module esi_manifest_word_sel
  import esi_manifest_pkg::*;
#(
  parameter int unsigned COMPRESSED_MANIFEST_SIZE = 1,
  parameter int unsigned ESI_VERSION              = 1,
  parameter int unsigned IDX_WIDTH                = 29
) (
  input  logic [IDX_WIDTH-1:0]                      idx,
  input  logic [COMPRESSED_MANIFEST_SIZE-1:0][7:0]  compressed_manifest,
  output logic [63:0]                               word,
  output logic                                      range_err
);

  localparam int unsigned NUM_WORDS = num_words(COMPRESSED_MANIFEST_SIZE);
  // Select width for the data-word table; the table is rounded up to a power
  // of two so every select value addresses a real (possibly zero) entry.
  localparam int unsigned SEL_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TBL_WORDS = 1 << SEL_WIDTH;
  // Compare width wide enough for both the full index and NUM_WORDS, so a
  // large address can never wrap into the valid range.
  localparam int unsigned CMP_WIDTH = (IDX_WIDTH > 63) ? IDX_WIDTH + 1 : 64;

  logic [TBL_WORDS-1:0][63:0] words;
  logic [CMP_WIDTH-1:0]       idx_ext;
  logic [CMP_WIDTH-1:0]       num_words_ext;
  logic [SEL_WIDTH-1:0]       sel;

  // Lay the manifest bytes out little-endian inside each word, zero past the end.
  for (genvar b = 0; b < TBL_WORDS * WORD_BYTES; b++) begin : g_byte
    if (b < COMPRESSED_MANIFEST_SIZE) begin : g_live
      assign words[b / WORD_BYTES][8 * (b % WORD_BYTES) +: 8] = compressed_manifest[b];
    end else begin : g_pad
      assign words[b / WORD_BYTES][8 * (b % WORD_BYTES) +: 8] = 8'h00;
    end
  end

  assign idx_ext       = CMP_WIDTH'(idx);
  assign num_words_ext = CMP_WIDTH'(NUM_WORDS);
  assign range_err     = (idx_ext > num_words_ext);
  // Data word k lives at table entry k-1; only meaningful when 1 <= idx <= NUM_WORDS.
  assign sel           = SEL_WIDTH'(idx_ext - CMP_WIDTH'(1));

  // Header at index 0, data words after it, zero for anything out of range.
  always_comb begin
    word = '0;
    if (idx_ext == '0) begin
      word[SIZE_LSB +: 32]    = 32'(COMPRESSED_MANIFEST_SIZE);
      word[VERSION_LSB +: 32] = 32'(ESI_VERSION);
    end else if (!range_err) begin
      word = words[sel];
    end
  end

endmodule

// File: rtl/esi_manifest_mmio_reader.sv
// Serves the compressed ESI manifest over a 64-bit MMIO read channel.
// Latency: 2-stage pipeline; response valid the cycle after the edge following accept.
// Backpressure: response holds under !resp_ready; s1 absorbs one more request, then req_ready drops.
module esi_manifest_mmio_reader
  import esi_manifest_pkg::*;
#(
  parameter int unsigned COMPRESSED_MANIFEST_SIZE = 1,
  parameter int unsigned ESI_VERSION              = 1,
  parameter int unsigned ADDR_WIDTH               = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [COMPRESSED_MANIFEST_SIZE-1:0][7:0]  compressed_manifest,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [ADDR_WIDTH-1:0]                     req_addr,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [63:0]                               resp_data,
  output logic                                      resp_error
);

  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 3;

  logic                 s1_valid;
  logic [IDX_WIDTH-1:0] s1_idx;
  logic                 s1_misaligned;
  logic                 s2_load;
  logic                 req_fire;
  logic [63:0]          sel_word;
  logic                 sel_range_err;
  logic                 s1_err;

  esi_manifest_word_sel #(
    .COMPRESSED_MANIFEST_SIZE (COMPRESSED_MANIFEST_SIZE),
    .ESI_VERSION              (ESI_VERSION),
    .IDX_WIDTH                (IDX_WIDTH)
  ) u_word_sel (
    .idx                 (s1_idx),
    .compressed_manifest (compressed_manifest),
    .word                (sel_word),
    .range_err           (sel_range_err)
  );

  // Stage 2 advances when it is empty or its current word is being consumed.
  // req_ready therefore has a combinational path from resp_ready, never from req_valid.
  assign s2_load   = s1_valid && (!resp_valid || resp_ready);
  assign req_ready = !s1_valid || s2_load;
  assign req_fire  = req_valid && req_ready;
  assign s1_err    = s1_misaligned || sel_range_err;

  // Stage 1: capture the word index and alignment error of each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_idx        <= '0;
      s1_misaligned <= 1'b0;
    end else if (req_fire) begin
      s1_valid      <= 1'b1;
      s1_idx        <= req_addr[ADDR_WIDTH-1:3];
      s1_misaligned <= |req_addr[2:0];
    end else if (s2_load) begin
      s1_valid      <= 1'b0;
    end
  end

  // Stage 2: response register; reload wins over handshake clear so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (s2_load) begin
      resp_valid <= 1'b1;
      resp_data  <= s1_err ? 64'h0 : sel_word;
      resp_error <= s1_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_esi_manifest_mmio_reader.sv
// Scoreboard bench for esi_manifest_mmio_reader with an 11-byte manifest.
// Latency: checks the 2-stage response timing on a header read.
// Backpressure: drives held-low and random resp_ready and checks hold/ordering.
module tb_esi_manifest_mmio_reader;

  localparam int unsigned SIZE = 11;
  localparam int unsigned VER  = 1;
  localparam int unsigned AW   = 32;
  localparam int unsigned NW   = (SIZE + 7) / 8;

  localparam int RR_ALWAYS = 0;
  localparam int RR_LOW    = 1;
  localparam int RR_RAND   = 2;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [SIZE-1:0][7:0] man_vec;
  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_addr;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [63:0]          resp_data;
  logic                 resp_error;

  logic [7:0]  man [SIZE];
  exp_t        sbq [$];
  int          hs_cyc [$];
  int          n_checks;
  int          n_fail;
  int          cyc;
  int          rr_mode;
  int          acc_cnt;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic        prev_err;
  exp_t        mon_e;

  esi_manifest_mmio_reader #(
    .COMPRESSED_MANIFEST_SIZE (SIZE),
    .ESI_VERSION              (VER),
    .ADDR_WIDTH               (AW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .compressed_manifest (man_vec),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_addr            (req_addr),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_data           (resp_data),
    .resp_error          (resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: what a read of byte address 'a' must return, straight from the address map.
  function automatic exp_t model(input logic [31:0] a);
    exp_t            e;
    longint unsigned idx;
    longint unsigned b;
    e.data = 64'h0;
    e.err  = 1'b0;
    idx    = longint'(a) / 8;
    if ((a % 8) != 0 || idx > NW) begin
      e.err = 1'b1;
      return e;
    end
    if (idx == 0) begin
      e.data = {32'(VER), 32'(SIZE)};
    end else begin
      for (int j = 0; j < 8; j++) begin
        b = (idx - 1) * 8 + longint'(j);
        if (b < SIZE) e.data[8*j +: 8] = man[int'(b)];
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request until accepted; expected response is queued at acceptance.
  task automatic issue(input logic [31:0] a);
    int t;
    t         = 0;
    req_valid = 1'b1;
    req_addr  = a;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        sbq.push_back(model(a));
        acc_cnt++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
      t++;
      if (t > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_timeout: addr %h never accepted within 200 cycles", a);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || resp_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", 64'(sbq.size()), 64'd0);
  endtask

  // resp_ready generator, updated just after each rising edge.
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        RR_LOW:  resp_ready = 1'b0;
        RR_RAND: resp_ready = ($urandom_range(0, 9) < 7);
        default: resp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each response handshake and checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(resp_valid), 64'd1);
        chk("hold_data", resp_data, prev_data);
        chk("hold_error", 64'(resp_error), 64'(prev_err));
      end
      if (resp_valid && resp_ready) begin
        hs_cyc.push_back(cyc);
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got data %h error %b with no request outstanding",
                   resp_data, resp_error);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_error", 64'(resp_error), 64'(mon_e.err));
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
      prev_err   = resp_error;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d outstanding", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] a;
    n_checks   = 0;
    n_fail     = 0;
    acc_cnt    = 0;
    rr_mode    = RR_ALWAYS;
    prev_stall = 1'b0;
    prev_data  = 64'h0;
    prev_err   = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    for (int i = 0; i < SIZE; i++) begin
      man[i]     = 8'(8'h10 + i);
      man_vec[i] = 8'(8'h10 + i);
    end

    // Reset state.
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'h0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Header read with latency check.
    issue(32'h0);
    @(negedge clk);
    chk("hdr_lat_early", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("hdr_lat_valid", 64'(resp_valid), 64'd1);
    chk("hdr_value_direct", resp_data, 64'h00000001_0000000B);
    drain();
    @(posedge clk);
    #1;

    // Data words and error cases back to back.
    issue(32'h8);
    issue(32'h10);
    issue(32'h4);
    issue(32'h18);
    issue(32'h8000_0008);
    drain();

    // Backpressure: resp_ready low for 5 cycles while 4 reads are offered.
    @(negedge clk);
    rr_mode = RR_LOW;
    @(posedge clk);
    #1;
    acc_cnt = 0;
    fork
      begin
        issue(32'h0);
        issue(32'h8);
        issue(32'h10);
        issue(32'h18);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_accepted", 64'(acc_cnt), 64'd2);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        chk("bp_first_data", resp_data, 64'h00000001_0000000B);
        @(negedge clk);
        hs_cyc.delete();
        rr_mode = RR_ALWAYS;
      end
    join
    drain();
    chk("bp_resp_count", 64'(hs_cyc.size()), 64'd4);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("bp_no_bubble", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);

    // Reset with one request in stage 2 and one in s1.
    @(negedge clk);
    rr_mode = RR_LOW;
    @(posedge clk);
    #1;
    issue(32'h8);
    issue(32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_data", resp_data, 64'h0);
    chk("midrst_resp_error", 64'(resp_error), 64'd0);
    sbq.delete();
    @(negedge clk);
    rr_mode = RR_ALWAYS;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_resp", 64'(resp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(32'h0);
    drain();

    // Randomized traffic with random response backpressure.
    @(negedge clk);
    rr_mode = RR_RAND;
    @(posedge clk);
    #1;
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = 32'($urandom_range(0, 3)) * 8;
      else if (r < 7) a = 32'($urandom_range(0, 3)) * 8 + 32'($urandom_range(1, 7));
      else if (r < 8) a = {1'b1, $urandom_range(0, 32'h0FFF_FFFF) & 28'hFFF_FFFF, 3'b000};
      else            a = $urandom;
      issue(a);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    rr_mode = RR_ALWAYS;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/esi_manifest_mmio_reader.md
# esi_manifest_mmio_reader

Serves the zlib-compressed ESI manifest to host software over a 64-bit MMIO read channel. It is the hardware counterpart of the cosim manifest path: both are driven from the same packed compressed-manifest byte vector, so real-hardware and cosim builds expose an identical manifest image. Requests are accepted at full rate through a two-stage pipeline, with backpressure on the response.

## Interface
Parameters:
- COMPRESSED_MANIFEST_SIZE, default 1: manifest length in bytes; must be at least 1.
- ESI_VERSION, default 1: int unsigned, reported in the header word.
- ADDR_WIDTH, default 32: byte-address width.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: asynchronous, active-high reset.
- compressed_manifest, in, [COMPRESSED_MANIFEST_SIZE-1:0][7:0]: manifest bytes; element 0 is the first byte; static after reset.
- req_valid, in, 1: read request valid.
- req_ready, out, 1: request accepted when req_valid && req_ready at posedge clk.
- req_addr, in, ADDR_WIDTH: byte address.
- resp_valid, out, 1: response valid.
- resp_ready, in, 1: response consumed when resp_valid && resp_ready.
- resp_data, out, 64: read data.
- resp_error, out, 1: request was misaligned or out of range.

## Operation
- NUM_WORDS = ceil(COMPRESSED_MANIFEST_SIZE/8). Word index = req_addr[ADDR_WIDTH-1:3].
- Index 0 is the header: data[31:0] = COMPRESSED_MANIFEST_SIZE, data[63:32] = ESI_VERSION.
- Index k, 1..NUM_WORDS: byte j (0..7) of the word at data[8j+7:8j] = compressed_manifest[8(k-1)+j]. Bytes past the manifest end read 0x00.
- req_addr[2:0] != 0, or index > NUM_WORDS: resp_data = 0 and resp_error = 1. The index is evaluated with the full address width, so there is no truncation or wrap.
- Stage 1 (s1): registers the index and error flag on accept.
- Stage 2: the output register holds resp_valid, resp_data and resp_error.
- Stage 2 loads when s1_valid && (!resp_valid || resp_ready).
- req_ready = !s1_valid || stage-2 load.
- resp_valid clears on handshake unless it reloads in the same cycle.
- Responses return in request order; there is no reordering and no drop.
- Reset (asynchronous, any time): s1_valid = 0, resp_valid = 0, resp_data = 0, resp_error = 0. In-flight requests are discarded. req_ready is 1 from the first cycle after reset deasserts.

## Timing
- Latency: a request accepted at edge N produces resp_valid high after edge N+1, so it is visible in the cycle following N+1.
- Throughput: one request per cycle while resp_ready = 1.
- Under backpressure: resp_data and resp_error stay stable while resp_valid && !resp_ready. One further request can be held in s1, after which req_ready drops.
- Simultaneous response handshake and s1 reload: the new word replaces the old one at the same edge, with no bubble.
- req_ready has no combinational path from req_valid. It depends combinationally on resp_ready; this path is accepted and documented.

## Structure
- Package esi_manifest_pkg holds:
  - header field offsets: SIZE_LSB = 0, VERSION_LSB = 32;
  - WORD_BYTES = 8;
  - function num_words(size) returning ceil(size/8).
- Sub-module esi_manifest_word_sel: purely combinational. Inputs are the index and the manifest vector; outputs are the 64-bit word and the range-error flag. It contains the header/data mux and the zero padding.
- The top level contains the two pipeline registers and the handshake logic only.

## Test plan
Configuration for all scenarios: SIZE = 11, ESI_VERSION = 1, bytes 0x10..0x1A.
- Header: read addr 0x0 gives 0x00000001_0000000B with error = 0, response 2 cycles after accept.
- Data words:
  - addr 0x8 gives 0x17161514_13121110.
  - addr 0x10 gives 0x00000000_001A1918 (zero-padded tail).
- Errors:
  - addr 0x4 (misaligned) gives data 0, error 1.
  - addr 0x18 (index 3 > NUM_WORDS = 2) gives data 0, error 1.
  - addr 0x8000_0008 gives data 0, error 1.
- Backpressure: issue 4 back-to-back reads (0x0, 0x8, 0x10, 0x18) with resp_ready held low for 5 cycles.
  - Two requests are accepted, then req_ready = 0.
  - The first response stays stable.
  - After release, responses arrive in order with no bubbles.
- Reset mid-operation: assert rst asynchronously with one request in s1 and one in stage 2.
  - Outputs go to 0 immediately.
  - No stale response appears after reset deasserts.
  - A subsequent read of 0x0 returns the header correctly.
